// File: rtl/grid_pixel_renderer.sv
// rtl/grid_pixel_renderer.sv - board/grid/cursor pixel compositor with counter-based cell tracking
//
// Ports:
//   clk_in        pixel clock
//   rst_n         asynchronous active-low reset
//   enable        visible-area flag, aligned with current_row/current_line
//   current_row   pixel x (raster order, one per clock)
//   current_line  pixel y
//   mouse_pos_x/y cursor position
//   cell_addr     registered cell index (row*COLS+col) to the status RAM
//   mask_addr     registered in-cell offset (off_y*CELL_W+off_x) to the mask ROM
//   cell_status   status of the cell addressed MEM_LAT cycles earlier
//   mask_bits     {ship, circle, cross} mask bits, same latency as cell_status
//   color_out     registered RGB444 pixel, MEM_LAT+2 cycles after its coordinates
//   hover_valid   mouse is inside the grid and the hover cell is up to date

module grid_pixel_renderer #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int CELL_W      = 80,
    parameter int CELL_H      = 60,
    parameter int LINE_W      = 2,
    parameter int CURSOR_HALF = 5,
    parameter int MEM_LAT     = 1,
    localparam int CELL_AW    = $clog2(COLS * ROWS),
    localparam int MASK_AW    = $clog2(CELL_W * CELL_H)
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [9:0]         current_row,
    input  logic [9:0]         current_line,
    input  logic [9:0]         mouse_pos_x,
    input  logic [9:0]         mouse_pos_y,
    output logic [CELL_AW-1:0] cell_addr,
    output logic [MASK_AW-1:0] mask_addr,
    input  logic [3:0]         cell_status,
    input  logic [2:0]         mask_bits,
    output logic [11:0]        color_out,
    output logic               hover_valid
);

    localparam int OX_W  = $clog2(CELL_W);
    localparam int OY_W  = $clog2(CELL_H);
    localparam int COL_W = $clog2(COLS + 1);
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam int HC_W  = 10;
    localparam int NF    = 5;

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_LINE   = 12'h00F;
    localparam logic [11:0] C_EMPTY  = 12'h0F0;
    localparam logic [11:0] C_HIT    = 12'hF00;
    localparam logic [11:0] C_MARK   = 12'hE91;
    localparam logic [11:0] C_OFF    = 12'h555;
    localparam logic [11:0] C_HOVER  = 12'h777;

    localparam logic signed [10:0] CUR_H = 11'(CURSOR_HALF);

    // ---------------- raster position counters ----------------
    logic [OX_W-1:0]  off_x_q, off_x_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [OY_W-1:0]  off_y_q, off_y_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [9:0]       prev_line_q;
    logic             line_chg;

    assign line_chg = (current_line != prev_line_q);

    // The *_d values describe the pixel currently on the inputs; they are
    // used directly for addresses and flags so the address lands at t+1.
    always_comb begin
        off_x_d = off_x_q;
        col_d   = col_q;
        if (current_row == '0) begin
            off_x_d = '0;
            col_d   = '0;
        end else if (off_x_q == OX_W'(CELL_W - 1)) begin
            off_x_d = '0;
            if (col_q != COL_W'(COLS))
                col_d = col_q + COL_W'(1);
        end else begin
            off_x_d = off_x_q + OX_W'(1);
        end
    end

    always_comb begin
        off_y_d = off_y_q;
        row_d   = row_q;
        if (line_chg) begin
            if (current_line == '0) begin
                off_y_d = '0;
                row_d   = '0;
            end else if (off_y_q == OY_W'(CELL_H - 1)) begin
                off_y_d = '0;
                if (row_q != ROW_W'(ROWS))
                    row_d = row_q + ROW_W'(1);
            end else begin
                off_y_d = off_y_q + OY_W'(1);
            end
        end
    end

    // ---------------- per-pixel overlay flags ----------------
    logic outside_d, grid_d, cursor_d, hover_d;
    logic grid_v, grid_h;
    logic signed [10:0] dx, dy;
    logic [HC_W-1:0] hov_col_q, hov_row_q;

    assign outside_d = (col_d == COL_W'(COLS)) || (row_d == ROW_W'(ROWS));

    // Only internal boundaries get a line; the outer frame stays cell content.
    assign grid_v = ((off_x_d >= OX_W'(CELL_W - LINE_W)) && (col_d < COL_W'(COLS - 1))) ||
                    ((off_x_d < OX_W'(LINE_W)) && (col_d != '0));
    assign grid_h = ((off_y_d >= OY_W'(CELL_H - LINE_W)) && (row_d < ROW_W'(ROWS - 1))) ||
                    ((off_y_d < OY_W'(LINE_W)) && (row_d != '0));
    assign grid_d = grid_v || grid_h;

    // Signed 11-bit difference so a cursor near 0 never wraps to the far edge.
    assign dx = $signed({1'b0, current_row})  - $signed({1'b0, mouse_pos_x});
    assign dy = $signed({1'b0, current_line}) - $signed({1'b0, mouse_pos_y});
    assign cursor_d = (dx <= CUR_H) && (dx >= -CUR_H) && (dy <= CUR_H) && (dy >= -CUR_H);

    assign hover_d = hover_valid && (HC_W'(col_d) == hov_col_q) && (HC_W'(row_d) == hov_row_q);

    // Stage 0 is aligned with cell_addr; stage MEM_LAT with cell_status.
    logic [NF-1:0] flag_pipe [0:MEM_LAT];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            off_x_q     <= '0;
            col_q       <= '0;
            off_y_q     <= '0;
            row_q       <= '0;
            prev_line_q <= '0;
            cell_addr   <= '0;
            mask_addr   <= '0;
            for (int i = 0; i <= MEM_LAT; i++)
                flag_pipe[i] <= '0;
        end else begin
            off_x_q     <= off_x_d;
            col_q       <= col_d;
            off_y_q     <= off_y_d;
            row_q       <= row_d;
            prev_line_q <= current_line;
            cell_addr   <= CELL_AW'(int'(row_d) * COLS + int'(col_d));
            mask_addr   <= MASK_AW'(int'(off_y_d) * CELL_W + int'(off_x_d));
            flag_pipe[0] <= {enable, outside_d, grid_d, cursor_d, hover_d};
            for (int i = 1; i <= MEM_LAT; i++)
                flag_pipe[i] <= flag_pipe[i-1];
        end
    end

    // ---------------- pixel composition ----------------
    logic f_en, f_out, f_grid, f_cur, f_hov;
    logic [11:0] pix_d;

    assign {f_en, f_out, f_grid, f_cur, f_hov} = flag_pipe[MEM_LAT];

    always_comb begin
        pix_d = C_BLACK;
        if (!f_en)
            pix_d = C_BLACK;
        else if (f_cur)
            pix_d = C_WHITE;
        else if (f_out)
            pix_d = C_BLACK;
        else if (f_grid)
            pix_d = C_LINE;
        else if (cell_status == 4'd0)
            pix_d = C_EMPTY;
        else if (|(cell_status[2:0] & mask_bits))
            pix_d = cell_status[3] ? C_HIT : C_MARK;
        else
            pix_d = f_hov ? C_HOVER : C_OFF;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            color_out <= C_BLACK;
        else
            color_out <= pix_d;
    end

    // ---------------- hover cell FSM ----------------
    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} hstate_t;

    hstate_t         state_q, state_d;
    logic [9:0]      mx_q, my_q, rem_q;
    logic [HC_W-1:0] hcol_q, hrow_q;
    logic            mouse_chg;
    logic            ld_mouse, sub_x, to_y, sub_y, commit;

    assign mouse_chg = (mouse_pos_x != mx_q) || (mouse_pos_y != my_q);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // A mouse change in any state restarts the division with fresh values.
    always_comb begin
        state_d = state_q;
        if (mouse_chg) begin
            state_d = DIV_X;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                DIV_X:   if (rem_q < 10'(CELL_W)) state_d = DIV_Y;
                DIV_Y:   if (rem_q < 10'(CELL_H)) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ld_mouse = mouse_chg;
        sub_x    = !mouse_chg && (state_q == DIV_X) && (rem_q >= 10'(CELL_W));
        to_y     = !mouse_chg && (state_q == DIV_X) && (rem_q <  10'(CELL_W));
        sub_y    = !mouse_chg && (state_q == DIV_Y) && (rem_q >= 10'(CELL_H));
        commit   = !mouse_chg && (state_q == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mx_q        <= '0;
            my_q        <= '0;
            rem_q       <= '0;
            hcol_q      <= '0;
            hrow_q      <= '0;
            hov_col_q   <= '0;
            hov_row_q   <= '0;
            hover_valid <= 1'b0;
        end else begin
            if (ld_mouse) begin
                mx_q        <= mouse_pos_x;
                my_q        <= mouse_pos_y;
                rem_q       <= mouse_pos_x;
                hcol_q      <= '0;
                hrow_q      <= '0;
                hover_valid <= 1'b0;
            end else if (sub_x) begin
                rem_q  <= rem_q - 10'(CELL_W);
                hcol_q <= hcol_q + HC_W'(1);
            end else if (to_y) begin
                rem_q <= my_q;
            end else if (sub_y) begin
                rem_q  <= rem_q - 10'(CELL_H);
                hrow_q <= hrow_q + HC_W'(1);
            end else if (commit) begin
                hover_valid <= (hcol_q < HC_W'(COLS)) && (hrow_q < HC_W'(ROWS));
                hov_col_q   <= hcol_q;
                hov_row_q   <= hrow_q;
            end
        end
    end

endmodule

// File: tb/tb_grid_pixel_renderer.sv
// tb/tb_grid_pixel_renderer.sv - self-checking bench for grid_pixel_renderer

module tb_grid_pixel_renderer;

    localparam int COLS = 8, ROWS = 8, CELL_W = 80, CELL_H = 60;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [9:0]  current_row = '0, current_line = '0;
    logic [9:0]  mouse_pos_x = 10'd1000, mouse_pos_y = 10'd1000;
    logic [5:0]  cell_addr;
    logic [12:0] mask_addr;
    logic [3:0]  cell_status = '0;
    logic [2:0]  mask_bits = '0;
    logic [11:0] color_out;
    logic        hover_valid;

    always #5 clk_in = ~clk_in;

    grid_pixel_renderer dut (
        .clk_in(clk_in), .rst_n(rst_n), .enable(enable),
        .current_row(current_row), .current_line(current_line),
        .mouse_pos_x(mouse_pos_x), .mouse_pos_y(mouse_pos_y),
        .cell_addr(cell_addr), .mask_addr(mask_addr),
        .cell_status(cell_status), .mask_bits(mask_bits),
        .color_out(color_out), .hover_valid(hover_valid)
    );

    logic [3:0] status_mem [0:63];
    logic [2:0] mask_mem [0:8191];

    // One-cycle latency RAM/ROM responders.
    always @(posedge clk_in) begin
        cell_status <= status_mem[cell_addr];
        mask_bits   <= mask_mem[mask_addr];
    end

    int tests = 0, fails = 0;
    int mx = 1000, my = 1000;
    bit armed = 1'b0;
    int cur_line = 0;
    logic [11:0] got   [0:1023];
    logic [11:0] exp_c [0:1023];

    task automatic chk(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s @%0d: observed %h expected %h", tag, idx, obs, expv);
        end
    endtask

    function automatic logic [11:0] model_px(input int x, input int y, input bit en);
        int col, row, ox, oy, dxa, dya;
        logic [3:0] st;
        logic [2:0] mk;
        bit hov_ok;
        if (!en) return 12'h000;
        dxa = (x > mx) ? x - mx : mx - x;
        dya = (y > my) ? y - my : my - y;
        if (dxa <= 5 && dya <= 5) return 12'hFFF;
        col = x / CELL_W; row = y / CELL_H;
        if (col >= COLS || row >= ROWS) return 12'h000;
        ox = x % CELL_W; oy = y % CELL_H;
        if ((ox >= CELL_W - 2 && col < COLS - 1) || (ox < 2 && col > 0) ||
            (oy >= CELL_H - 2 && row < ROWS - 1) || (oy < 2 && row > 0)) return 12'h00F;
        st = status_mem[row * COLS + col];
        if (st == 4'd0) return 12'h0F0;
        mk = mask_mem[oy * CELL_W + ox];
        if ((st[2:0] & mk) != 3'd0) return st[3] ? 12'hF00 : 12'hE91;
        hov_ok = armed && mx < COLS * CELL_W && my < ROWS * CELL_H;
        if (hov_ok && mx / CELL_W == col && my / CELL_H == row) return 12'h777;
        return 12'h555;
    endfunction

    task automatic set_mouse(input int x, input int y);
        @(posedge clk_in); #1;
        mouse_pos_x = 10'(x); mouse_pos_y = 10'(y);
        mx = x; my = y;
        if (x != 0 || y != 0) armed = 1'b1;
        repeat (40) @(posedge clk_in);
        @(negedge clk_in);
        chk("hover_settle", x, hover_valid, (armed && x < COLS * CELL_W && y < ROWS * CELL_H));
    endtask

    task automatic goto_line(input int y);
        if (y < cur_line) begin
            @(posedge clk_in); #1;
            enable = 1'b0; current_row = '0; current_line = '0;
            cur_line = 0;
        end
        while (cur_line < y) begin
            @(posedge clk_in); #1;
            enable = 1'b0; current_row = '0;
            cur_line++;
            current_line = 10'(cur_line);
        end
    endtask

    // mode 0: visible-area enable, 1: enable everywhere, 2: visible with random dropouts
    task automatic sweep(input int y, input int xmax, input int mode);
        bit e;
        for (int i = 0; i <= xmax + 3; i++) begin
            @(posedge clk_in); #1;
            if (i <= xmax) begin
                current_row = 10'(i);
                if (mode == 1)      e = 1'b1;
                else if (mode == 0) e = (i < 640 && y < 480);
                else                e = (i < 640 && y < 480) && (i == 0 || $urandom_range(0, 7) != 0);
                enable = e;
                exp_c[i] = model_px(i, y, e);
            end else begin
                enable = 1'b0;
            end
            @(negedge clk_in);
            if (i < 3) chk("pre_latency_black", i, color_out, 12'h000);
            else begin
                got[i-3] = color_out;
                chk($sformatf("color y=%0d", y), i - 3, color_out, exp_c[i-3]);
            end
            if (i >= 1 && i - 1 <= xmax && i - 1 < 640 && y < 480) begin
                chk("cell_addr", i - 1, cell_addr, (y / CELL_H) * COLS + (i - 1) / CELL_W);
                chk("mask_addr", i - 1, mask_addr, (y % CELL_H) * CELL_W + (i - 1) % CELL_W);
            end
        end
    endtask

    task automatic wait_hover(input string tag, input int budget);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk_in); n++;
            @(negedge clk_in);
            seen = (hover_valid === 1'b1);
        end
        chk(tag, n, seen, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) status_mem[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 8192; i++) mask_mem[i] = 3'($urandom_range(0, 7));
        status_mem[9] = 4'b1001;
        mask_mem[10 * CELL_W + 10] = 3'b001;
        mask_mem[10 * CELL_W + 11] = 3'b000;

        // reset state
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_color", 0, color_out, 12'h000);
        chk("rst_cell_addr", 0, cell_addr, 0);
        chk("rst_mask_addr", 0, mask_addr, 0);
        chk("rst_hover", 0, hover_valid, 1'b0);
        rst_n = 1'b1;
        armed = 1'b1;
        repeat (40) @(posedge clk_in);

        // line 0 sweep: address sequence and first-pixel latency
        sweep(0, 700, 0);

        // grid lines at an internal boundary, none on the outer edge
        goto_line(30);
        sweep(30, 200, 0);
        for (int x = 158; x <= 161; x++) chk("gridline", x, got[x], 12'h00F);
        chk("edge_x0_not_line", 0, (got[0] == 12'h00F), 1'b0);
        chk("edge_x1_not_line", 1, (got[1] == 12'h00F), 1'b0);

        // cell 9 content
        goto_line(70);
        sweep(70, 200, 0);
        chk("cell9_hit", 90, got[90], 12'hF00);
        chk("cell9_off", 91, got[91], 12'h555);

        // randomized lines and mouse positions
        for (int k = 0; k < 5; k++) begin
            set_mouse($urandom_range(0, 639), $urandom_range(0, 479));
            goto_line(100 + k * 70 + $urandom_range(0, 50));
            sweep(cur_line, 700, 2);
        end

        // cursor at origin must not wrap to the far edge
        set_mouse(0, 0);
        goto_line(0);
        for (int y = 0; y <= 6; y++) begin
            goto_line(y);
            sweep(y, 1023, 1);
            for (int x = 0; x <= 6; x++)
                chk($sformatf("cursor y=%0d", y), x, (got[x] == 12'hFFF), (x <= 5 && y <= 5));
            for (int x = 1018; x <= 1023; x++)
                chk($sformatf("cursor_wrap y=%0d", y), x, (got[x] == 12'hFFF), 1'b0);
        end

        // hover tracking
        @(posedge clk_in); #1;
        mouse_pos_x = 10'd100; mouse_pos_y = 10'd100; mx = 100; my = 100;
        wait_hover("hover_first", COLS + ROWS + 3);
        @(posedge clk_in); #1;
        mouse_pos_x = 10'd700; mx = 700;
        @(posedge clk_in); @(negedge clk_in);
        chk("hover_drop", 700, hover_valid, 1'b0);
        repeat (40) @(posedge clk_in);
        @(negedge clk_in);
        chk("hover_outside", 700, hover_valid, 1'b0);
        @(posedge clk_in); #1;
        mouse_pos_x = 10'd100; mx = 100;
        wait_hover("hover_back", COLS + ROWS + 3);
        goto_line(70);
        sweep(70, 200, 0);
        chk("hover_bg", 91, got[91], 12'h777);

        // asynchronous reset in the middle of a visible line
        goto_line(100);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_in); #1;
            current_row = 10'(i); enable = 1'b1;
        end
        @(posedge clk_in); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_color_now", 0, color_out, 12'h000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("midrst_color", i, color_out, 12'h000);
            chk("midrst_cell_addr", i, cell_addr, 0);
            chk("midrst_hover", i, hover_valid, 1'b0);
        end
        rst_n = 1'b1;
        enable = 1'b0;
        armed = (mx != 0 || my != 0);
        cur_line = 2000;
        repeat (40) @(posedge clk_in);
        goto_line(70);
        sweep(70, 300, 2);
        chk("post_rst_hover_bg", 91, got[91], exp_c[91]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grid_pixel_renderer.md
Name: grid_pixel_renderer

Overview:
- Parametrised successor of the game-board VGA pixel colouriser.
- Takes raster coordinates from the VGA timing block and tracks cell and in-cell offsets with counters instead of multipliers.
- Fetches cell status and shape-mask bits from external RAM/ROM with a fixed latency, and composes the board, grid lines, hover highlight and mouse cursor into a registered 12-bit RGB pixel.
- Grid size, cell size, line width, cursor size and memory latency are all parameters.

Parameters:
- COLS, 8, number of cell columns.
- ROWS, 8, number of cell rows.
- CELL_W, 80, cell width in pixels.
- CELL_H, 60, cell height in pixels.
- LINE_W, 2, grid-line half-thickness in pixels (each side of a cell boundary).
- CURSOR_HALF, 5, cursor square half-size in pixels.
- MEM_LAT, 1, cycles from cell_addr/mask_addr to cell_status/mask_bits (range 1..4).
- Localparams: CELL_AW = clog2(COLS*ROWS); MASK_AW = clog2(CELL_W*CELL_H).

Ports:
- clk_in  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  visible-area flag, aligned with the coordinates
- current_row  in  10  pixel x, raster order, one per clock
- current_line  in  10  pixel y
- mouse_pos_x  in  10  cursor x
- mouse_pos_y  in  10  cursor y
- cell_addr  out  CELL_AW  cell index = row*COLS+col, registered
- mask_addr  out  MASK_AW  in-cell offset = off_y*CELL_W+off_x, registered
- cell_status  in  4  status of the cell_addr issued MEM_LAT cycles earlier
- mask_bits  in  3  {ship, circle, cross} mask bits for that mask_addr, same latency
- color_out  out  12  RGB444 pixel, registered
- hover_valid  out  1  mouse lies inside the grid and the hover result is current

Behaviour:
- Clock and reset (already decided): one clock clk_in; rst_n is asynchronous, active-low.
- Reset values: color_out=12'h000, cell_addr=0, mask_addr=0, hover_valid=0. All counters, pipeline flags and the FSM return to 0/IDLE.
- X counters:
  - current_row==0 clears off_x and col.
  - Otherwise off_x increments each clock; at CELL_W-1 it wraps to 0 and col increments.
  - col saturates at COLS, meaning outside the grid.
- Y counters:
  - Update only when current_line differs from the registered previous line.
  - current_line==0 clears off_y and row; otherwise off_y increments, wrapping at CELL_H-1 with row incrementing, saturating at ROWS.
- Pipeline:
  - Inputs are sampled at cycle t; cell_addr and mask_addr are registered at t+1.
  - Overlay flags are delayed MEM_LAT+1 stages: enable, outside, gridline, cursor, hover.
  - color_out is valid at t+MEM_LAT+2.
- Grid line (internal boundaries only):
  - Vertical: (off_x>=CELL_W-LINE_W and col<COLS-1) or (off_x<LINE_W and col>0).
  - Horizontal: the same rule on off_y/row.
- Cursor: |x-mouse_x|<=CURSOR_HALF and |y-mouse_y|<=CURSOR_HALF, computed in 11-bit signed arithmetic. No wrap at mouse coordinate 0.
- Cell content:
  - status==0 -> 12'h0F0.
  - Otherwise on = |(status[2:0] & mask_bits).
  - on -> (status[3] ? 12'hF00 : 12'hE91).
  - off -> 12'h555, or 12'h777 if the pixel is in the hover cell.
- Priority, highest first: enable low -> 12'h000; cursor -> 12'hFFF; outside grid -> 12'h000; grid line -> 12'h00F; cell content.
- Hover FSM (IDLE, DIV_X, DIV_Y, DONE):
  - IDLE: on a change in mouse_pos_x or mouse_pos_y, latch both and clear hover_valid.
  - DIV_X: repeated subtraction of CELL_W gives hcol, one step per clock. DIV_Y does the same with CELL_H for hrow.
  - DONE: hover_valid=(hcol<COLS && hrow<ROWS); hover cell is updated; return to IDLE.
  - A mouse change mid-computation restarts at DIV_X with the new values.
  - While hover_valid=0, no highlight is drawn.
- Async reset mid-frame: outputs go black immediately; the counters resynchronise at the next current_row==0 / line change.

Test Plan:
- Reset asserted mid-frame with enable=1 -> color_out=12'h000 immediately; cell_addr=0 and hover_valid=0 until release.
- Raster sweep of row y=0 with defaults -> cell_addr goes 0..7 changing at x=80k. mask_addr=x-80*col. First color_out appears exactly MEM_LAT+2=3 clocks after x=0.
- Status model cell 9=4'b1001 with cross mask set at offset (10,10), pixel (90,70) -> 12'hF00. Neighbouring offset with no mask bit -> 12'h555.
- Pixels x=158..161 at y=30 -> 12'h00F. Pixels x=0..1 (outer edge) -> cell content, not line colour.
- Mouse at (0,0) -> white square x,y in 0..5 only. No white at x=1018..1023 (wrap check).
- Mouse moves (100,100)->(700,100) -> hover_valid drops within 1 clock. hover_valid stays 0 after DONE (col 8 is outside the grid). Moving back to (100,100) -> hover_valid=1 within COLS+ROWS+3 clocks and cell 9 background reads 12'h777.
